// File: rtl/reg_ctrl_pkg.sv
// Shared types and constants for the register-file control sequencer.
// Latency: n/a (types, constants and one helper only).
// Backpressure: n/a.
//
// Contents: opcode, FSM state and decoded op-class enums, halt encoding,
// label count, ALU op encoding and the opcode -> alu_op mapping.
package reg_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_SLT  = 3'b011,
        OP_RSV  = 3'b100,
        OP_LBL  = 3'b101,
        OP_BR   = 3'b110,
        OP_HALT = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LBL,
        CLS_BR,
        CLS_HALT,
        CLS_ILL
    } op_class_t;

    localparam logic [8:0] HALT_INSTR = 9'h1FF;
    localparam logic [2:0] NUM_LABELS = 3'd6;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_SLT = 2'b11;

    function automatic logic [1:0] alu_op_of(input logic [2:0] opc);
        logic [1:0] r;
        r = ALU_ADD;
        case (opc)
            OP_SUB:  r = ALU_SUB;
            OP_AND:  r = ALU_AND;
            OP_SLT:  r = ALU_SLT;
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reg_ctrl_decode.sv
// Instruction decoder: opcode class, register fields, illegal flag.
// Latency: purely combinational.
// Backpressure: none; evaluated on the latched instruction.
//
// Ports: instr in; op_class, alu_op, fld_hi ([5:3]), fld_lo ([2:0]), illegal out.
// Macro REG_CTRL_LABEL_EN enables LBL/BR decode; without it they are illegal.
import reg_ctrl_pkg::*;

module reg_ctrl_decode #(
    parameter int INSTR_W = 9
) (
    input  logic [INSTR_W-1:0] instr,
    output op_class_t          op_class,
    output logic [1:0]         alu_op,
    output logic [2:0]         fld_hi,
    output logic [2:0]         fld_lo,
    output logic               illegal
);

    opcode_t opc;

    assign opc     = opcode_t'(instr[8:6]);
    assign fld_hi  = instr[5:3];
    assign fld_lo  = instr[2:0];
    assign alu_op  = alu_op_of(instr[8:6]);
    assign illegal = (op_class == CLS_ILL);

    always_comb begin
        op_class = CLS_ILL;
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_SLT: op_class = CLS_ALU;
`ifdef REG_CTRL_LABEL_EN
            // Label index lives in [5:3] for both LBL (write) and BR (read).
            OP_LBL: if (fld_hi < NUM_LABELS) op_class = CLS_LBL;
            OP_BR:  if (fld_hi < NUM_LABELS) op_class = CLS_BR;
`endif
            OP_HALT: if (instr == HALT_INSTR) op_class = CLS_HALT;
            default: op_class = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/reg_ctrl_sequencer.sv
// Multi-cycle sequencer: decode, register read, ALU handshake, write-back, branch.
// Latency: ALU op 3+N cycles (N EXEC cycles), LBL 3 cycles, BR 2 cycles per instr.
// Backpressure: instr_ready only in IDLE; fetch holds instr until accepted.
//
// Ports: clk/reset (sync, active-high); instr_valid/instr/instr_ready from fetch;
// rs1/rs2/rd/label_rs/strobes/write_data/condition_bit to the register file,
// regA_i/regB_i back; alu_start/alu_op/alu_a/alu_b to ALU, alu_done/alu_result/
// alu_cond back; branch_valid/branch_target, illegal_op pulse, halted flag.
// Macro REG_CTRL_LABEL_EN enables LBL/BR; otherwise label/branch outputs are 0.
import reg_ctrl_pkg::*;

module reg_ctrl_sequencer #(
    parameter int DATA_W  = 8,
    parameter int INSTR_W = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    input  logic [DATA_W-1:0]  regA_i,
    input  logic [DATA_W-1:0]  regB_i,
    output logic [2:0]         rs1,
    output logic [2:0]         rs2,
    output logic [2:0]         rd,
    output logic [3:0]         label_rs,
    output logic               label_read,
    output logic               label_write,
    output logic               reg_write,
    output logic [DATA_W-1:0]  write_data,
    output logic               condition_bit,
    output logic               alu_start,
    output logic [1:0]         alu_op,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic               alu_done,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_cond,
    output logic               branch_valid,
    output logic [DATA_W-1:0]  branch_target,
    output logic               illegal_op,
    output logic               halted
);

    state_t              state, state_nxt;
    logic [INSTR_W-1:0]  instr_q;
    logic [DATA_W-1:0]   alu_a_q, alu_b_q, result_q;
    logic                cond_q;
    logic                exec_first;

    op_class_t           op_class;
    logic [1:0]          dec_alu_op;
    logic [2:0]          fld_hi, fld_lo;
    logic                dec_illegal;

    reg_ctrl_decode #(.INSTR_W(INSTR_W)) u_decode (
        .instr    (instr_q),
        .op_class (op_class),
        .alu_op   (dec_alu_op),
        .fld_hi   (fld_hi),
        .fld_lo   (fld_lo),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            instr_q    <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            result_q   <= '0;
            cond_q     <= 1'b0;
            exec_first <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: if (instr_valid) instr_q <= instr;
                ST_READ: begin
                    if (op_class == CLS_ALU) begin
                        alu_a_q    <= regA_i;
                        alu_b_q    <= regB_i;
                        exec_first <= 1'b1;
                    end else if (op_class == CLS_LBL) begin
                        // LBL reuses the A operand register to hold the copied value.
                        alu_a_q <= regA_i;
                    end
                end
                ST_EXEC: begin
                    exec_first <= 1'b0;
                    if (alu_done) begin
                        result_q <= alu_result;
                        cond_q   <= alu_cond;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef REG_CTRL_LABEL_EN
    logic              branch_pend_q;
    logic [DATA_W-1:0] branch_target_q;
    logic              branch_take;

    // Branch is decided in READ and presented during the following IDLE cycle.
    assign branch_take = (state == ST_READ) && (op_class == CLS_BR) && (regA_i != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_pend_q   <= 1'b0;
            branch_target_q <= '0;
        end else begin
            branch_pend_q <= branch_take;
            if (branch_take) branch_target_q <= regB_i;
        end
    end

    assign branch_valid  = branch_pend_q;
    assign branch_target = branch_target_q;
`else
    assign branch_valid  = 1'b0;
    assign branch_target = '0;
`endif

    // Ready is masked while reset is held so every output reads 0 in reset.
    assign instr_ready = (state == ST_IDLE) && !reset;
    assign halted      = (state == ST_HALT);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;

    always_comb begin
        state_nxt     = state;
        rs1           = '0;
        rs2           = '0;
        rd            = '0;
        label_rs      = '0;
        label_read    = 1'b0;
        label_write   = 1'b0;
        reg_write     = 1'b0;
        write_data    = '0;
        condition_bit = 1'b0;
        alu_start     = 1'b0;
        alu_op        = '0;
        illegal_op    = 1'b0;
        case (state)
            ST_IDLE: if (instr_valid) state_nxt = ST_READ;
            ST_READ: begin
                if (dec_illegal) begin
                    illegal_op = 1'b1;
                    state_nxt  = ST_IDLE;
                end else begin
                    case (op_class)
                        CLS_ALU: begin
                            rs1       = fld_hi;
                            rs2       = fld_lo;
                            state_nxt = ST_EXEC;
                        end
`ifdef REG_CTRL_LABEL_EN
                        CLS_LBL: begin
                            rs1       = fld_lo;
                            state_nxt = ST_WB;
                        end
                        CLS_BR: begin
                            label_read = 1'b1;
                            label_rs   = {1'b0, fld_hi};
                            state_nxt  = ST_IDLE;
                        end
`endif
                        CLS_HALT: state_nxt = ST_HALT;
                        default:  state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_EXEC: begin
                alu_start = exec_first;
                alu_op    = dec_alu_op;
                if (alu_done) state_nxt = ST_WB;
            end
            ST_WB: begin
                rd        = fld_hi;
                state_nxt = ST_IDLE;
                if (op_class == CLS_ALU) begin
                    reg_write     = 1'b1;
                    write_data    = result_q;
                    condition_bit = cond_q;
                end
`ifdef REG_CTRL_LABEL_EN
                else if (op_class == CLS_LBL) begin
                    label_write = 1'b1;
                    write_data  = alu_a_q;
                end
`endif
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_ctrl_sequencer.sv
// Directed, scoreboarded bench for reg_ctrl_sequencer.
// Latency: checks WB/branch timing against the cycle counts of each op class.
// Backpressure: instructions are offered only while instr_ready is high.
module tb_reg_ctrl_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [8:0] instr;
    logic       instr_ready;
    logic [7:0] regA_i, regB_i;
    logic [2:0] rs1, rs2, rd;
    logic [3:0] label_rs;
    logic       label_read, label_write, reg_write;
    logic [7:0] write_data;
    logic       condition_bit, alu_start;
    logic [1:0] alu_op;
    logic [7:0] alu_a, alu_b;
    logic       alu_done;
    logic [7:0] alu_result;
    logic       alu_cond;
    logic       branch_valid;
    logic [7:0] branch_target;
    logic       illegal_op, halted;

    always #5 clk = ~clk;

    reg_ctrl_sequencer #(.DATA_W(8), .INSTR_W(9)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .regA_i(regA_i), .regB_i(regB_i),
        .rs1(rs1), .rs2(rs2), .rd(rd), .label_rs(label_rs),
        .label_read(label_read), .label_write(label_write), .reg_write(reg_write),
        .write_data(write_data), .condition_bit(condition_bit),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .alu_cond(alu_cond),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .illegal_op(illegal_op), .halted(halted)
    );

    // Register file / label file model.
    logic [7:0] rf [8];
    logic [7:0] lbl_a, lbl_b;
    initial begin
        rf[0] = 8'h00; rf[1] = 8'h05; rf[2] = 8'h07; rf[3] = 8'h03;
        rf[4] = 8'hF0; rf[5] = 8'h3C; rf[6] = 8'h81; rf[7] = 8'hFF;
        lbl_a = 8'h00; lbl_b = 8'h00;
    end
    assign regA_i = label_read ? lbl_a : rf[rs1];
    assign regB_i = label_read ? lbl_b : rf[rs2];

    // ALU model: done arrives alu_lat cycles after the start cycle (0 = same cycle).
    int alu_lat = 1;
    int alu_cnt = 0;
    always_comb begin
        case (alu_op)
            2'b00:   alu_result = alu_a + alu_b;
            2'b01:   alu_result = alu_a - alu_b;
            2'b10:   alu_result = alu_a & alu_b;
            default: alu_result = {7'b0, ($signed(alu_a) < $signed(alu_b))};
        endcase
    end
    assign alu_cond = (alu_result == 8'h00);

    initial alu_done = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            alu_cnt  = 0;
            alu_done = 1'b0;
        end else if (alu_start) begin
            if (alu_lat == 0) alu_done = 1'b1;
            else begin
                alu_cnt  = alu_lat;
                alu_done = 1'b0;
            end
        end else if (alu_cnt > 0) begin
            alu_cnt  = alu_cnt - 1;
            alu_done = (alu_cnt == 0);
        end else begin
            alu_done = 1'b0;
        end
    end

    // Scoreboard of register-file writes and branches (kind 0 reg, 1 label, 2 branch).
    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] addr;
        logic [7:0] data;
        logic       cond;
    } ev_t;
    ev_t exp_q[$];
    ev_t mon_o, mon_e;

    int n_chk  = 0;
    int n_fail = 0;
    int ill_cnt = 0;
    int br_cnt  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (illegal_op === 1'b1) ill_cnt++;
        if (branch_valid === 1'b1) br_cnt++;
        if (reg_write || label_write || branch_valid) begin
            mon_o.kind = reg_write ? 2'd0 : (label_write ? 2'd1 : 2'd2);
            mon_o.addr = branch_valid ? 3'd0 : rd;
            mon_o.data = branch_valid ? branch_target : write_data;
            mon_o.cond = reg_write ? condition_bit : 1'b0;
            chk("sb_expected_event", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("sb_event", 64'(mon_o), 64'(mon_e));
            end
        end
    end

    task automatic send(input logic [8:0] i);
        int k;
        k = 0;
        while (!instr_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", 64'(instr_ready), 64'd1);
        instr       = i;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    // Counts negedges until a write strobe, bounded.
    task automatic wait_write(output int n);
        n = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            n++;
            if (reg_write || label_write) break;
        end
    endtask

    task automatic run_alu(input logic [8:0] i, input int lat, input logic [7:0] res,
                           input logic cond, input string tag);
        int n;
        ev_t e;
        e.kind = 2'd0; e.addr = i[5:3]; e.data = res; e.cond = cond;
        exp_q.push_back(e);
        alu_lat = lat;
        send(i);
        @(negedge clk);
        chk({tag, "_rs"}, 64'({rs1, rs2}), 64'({i[5:3], i[2:0]}));
        @(negedge clk);
        chk({tag, "_start"}, 64'({alu_start, alu_op, alu_a, alu_b}),
            64'({1'b1, i[7:6], rf[i[5:3]], rf[i[2:0]]}));
        wait_write(n);
        chk({tag, "_latency"}, 64'(n + 2), 64'(lat + 3));
    endtask

    task automatic expect_illegal(input logic [8:0] i, input string tag);
        int c0;
        c0 = ill_cnt;
        send(i);
        repeat (3) @(negedge clk);
        chk(tag, 64'(ill_cnt - c0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int b0;
        ev_t e;
        reset       = 1'b1;
        instr_valid = 1'b1;
        instr       = 9'b000_001_010;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            64'({instr_ready, rs1, rs2, rd, label_rs, label_read, label_write, reg_write,
                 write_data, condition_bit, alu_start, alu_op, alu_a, alu_b,
                 branch_valid, branch_target, illegal_op, halted}), 64'd0);
        instr_valid = 1'b0;
        reset       = 1'b0;
        #1;
        chk("ready_after_reset", 64'(instr_ready), 64'd1);
        @(negedge clk);

        run_alu(9'b000_001_010, 1, 8'd12,  1'b0, "add");
        run_alu(9'b001_010_001, 0, 8'h02,  1'b0, "sub");
        run_alu(9'b010_100_101, 2, 8'h30,  1'b0, "and");
        run_alu(9'b011_101_001, 1, 8'h00,  1'b1, "slt");

`ifdef REG_CTRL_LABEL_EN
        // Taken branch through label 3.
        lbl_a = 8'h01; lbl_b = 8'h40;
        e.kind = 2'd2; e.addr = 3'd0; e.data = 8'h40; e.cond = 1'b0;
        exp_q.push_back(e);
        b0 = br_cnt;
        send(9'b110_011_000);
        @(negedge clk);
        chk("br_read", 64'({label_read, label_rs}), 64'({1'b1, 4'd3}));
        @(negedge clk);
        chk("br_pulse", 64'({branch_valid, branch_target}), 64'({1'b1, 8'h40}));
        @(negedge clk);
        chk("br_single_pulse", 64'(br_cnt - b0), 64'd1);
        // Not taken.
        lbl_a = 8'h00;
        b0 = br_cnt;
        send(9'b110_011_000);
        repeat (3) @(negedge clk);
        chk("br_not_taken", 64'(br_cnt - b0), 64'd0);
        // Valid LBL: label 3 <= r2.
        e.kind = 2'd1; e.addr = 3'd3; e.data = rf[2]; e.cond = 1'b0;
        exp_q.push_back(e);
        send(9'b101_011_010);
        wait_write(n);
        chk("lbl_latency", 64'(n), 64'd2);
`else
        lbl_a = 8'h01; lbl_b = 8'h40;
        b0 = br_cnt;
        expect_illegal(9'b110_011_000, "br_disabled_illegal");
        chk("br_disabled_no_pulse", 64'(br_cnt - b0), 64'd0);
        expect_illegal(9'b101_011_010, "lbl_disabled_illegal");
`endif
        expect_illegal(9'b101_110_000, "lbl_index6_illegal");
        expect_illegal(9'b110_111_000, "br_index7_illegal");
        expect_illegal(9'b111_000_001, "op111_illegal");
        expect_illegal(9'b100_001_010, "op100_illegal");

        // Reset while EXEC waits on a slow ALU: no write may follow.
        alu_lat = 6;
        send(9'b000_001_010);
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_exec", 64'(alu_start), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_reset_quiet", 64'({instr_ready, alu_start, reg_write}), 64'd0);
        reset = 1'b0;
        #1;
        chk("abort_back_idle", 64'(instr_ready), 64'd1);
        repeat (10) @(negedge clk);
        alu_lat = 1;

        // Halt is sticky until reset, even with fetch offering work.
        send(9'h1FF);
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = 9'b000_001_010;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("halt_hold", 64'({halted, instr_ready}), 64'b10);
        end
        instr_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("halt_cleared", 64'({halted, instr_ready}), 64'b01);
        repeat (3) @(negedge clk);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_ctrl_sequencer.md
# reg_ctrl_sequencer

Multi-cycle control sequencer that drives the 8-bit processor's register file.
- Accepts 9-bit instructions from fetch and decodes them.
- Issues register-file read addresses and captures the operands.
- Hands the operands to the ALU and waits for it to finish.
- Issues the write-back strobes: general register, condition bit, or label register.
- Also raises branch requests resolved through the label registers.

## Interface
Parameters:
- DATA_W, 8, datapath width
- INSTR_W, 9, instruction width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- instr_valid  in  1  fetch has an instruction
- instr  in  9  [8:6] opcode, [5:3] rd/rs1, [2:0] rs2
- instr_ready  out  1  sequencer accepts an instruction this cycle
- regA_i, regB_i  in  8  register file read data (combinational)
- rs1, rs2, rd  out  3  register file addresses
- label_rs  out  4  label index for reads
- label_read, label_write, reg_write  out  1  register file strobes
- write_data  out  8  write-back value
- condition_bit  out  1  condition value written with reg_write
- alu_start  out  1  one-cycle start pulse
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 SLT
- alu_a, alu_b  out  8  registered operands
- alu_done  in  1  ALU result valid
- alu_result  in  8  ALU result
- alu_cond  in  1  ALU condition output
- branch_valid  out  1  one-cycle branch pulse
- branch_target  out  8  label value
- illegal_op  out  1  one-cycle pulse on an undecodable instruction
- halted  out  1  sticky halt flag

## Operation
- FSM states: IDLE, READ, EXEC, WB, HALT.
- IDLE: instr_ready=1. On instr_valid, latch instr and go to READ.
- READ (1 cycle):
  - ALU ops 000–011: drive rs1=[5:3] and rs2=[2:0]; capture regA_i and regB_i into alu_a and alu_b; go to EXEC.
  - LBL (101): rs1=[2:0]; capture regA_i; go to WB.
  - BR (110): label_read=1, label_rs={1'b0,[5:3]}; if regA_i≠0, pulse branch_valid next cycle with branch_target=regB_i; go to IDLE.
- EXEC:
  - alu_start=1 in the first EXEC cycle only.
  - Wait for alu_done; alu_done may arrive in the start cycle.
  - On alu_done, capture alu_result and alu_cond; go to WB.
- WB (1 cycle):
  - ALU op: reg_write=1, rd=[5:3], write_data=result, condition_bit=alu_cond.
  - LBL: label_write=1, rd=[5:3], write_data=captured regA.
  - Go to IDLE.
- HALT: entered when instr==9'h1FF. instr_ready=0 and halted=1 until reset.
- Illegal cases: LBL or BR with label index >5, or opcode 111 other than HALT.
  - Pulse illegal_op; make no register-file write; return to IDLE.
- Strobes (reg_write, label_write, label_read, alu_start, branch_valid) are high only in the states listed above; low otherwise.

## Timing
- Reset values: all outputs 0; state IDLE. instr_ready rises the first cycle after reset deasserts.
- Reset mid-operation: abort at the next edge. No write strobe is issued, alu_start drops, any pending branch is discarded.
- The register file writes on the falling edge within the WB cycle. Data and address are stable for the whole WB cycle.
- ALU op latency from acceptance edge to WB cycle: 2 + N cycles, where N is the number of EXEC cycles (N≥1).
  - Instruction throughput: one instruction per 3+N cycles.
- LBL: accept → READ → WB, 3 cycles per instruction.
- BR: accept → READ → IDLE, 2 cycles per instruction. branch_valid is asserted during the IDLE cycle.
- instr_valid is ignored outside IDLE. No instruction is lost: fetch holds instr until instr_ready.

## Configuration
- REG_CTRL_LABEL_EN:
  - Defined: LBL and BR are decoded as described above.
  - Undefined: opcodes 101 and 110 are illegal (illegal_op pulse, no write). label_read, label_write, and branch_valid are tied 0; branch_target is tied 0.

## Structure
- Package reg_ctrl_pkg holds:
  - opcode enum (OP_ADD..OP_HALT)
  - state enum
  - HALT_INSTR=9'h1FF
  - NUM_LABELS=6
  - alu_op encoding
- Natural sub-module: reg_ctrl_decode. It is combinational: instr → op class, field extraction, illegal flag. The FSM stays in the top module.

## Test plan
- Reset with instr_valid=1 → all outputs 0; instr_ready=1 on the first cycle after reset deasserts.
- ADD instr=9'b000_001_010, regs 1=5 and 2=7, alu_done 1 cycle after start → alu_a=5, alu_b=7; WB cycle with reg_write=1, rd=1, write_data=12.
- BR with label index 3, regA_i=1, regB_i=8'h40 → branch_valid pulse with target 8'h40; no reg_write. Repeat with regA_i=0 → no pulse.
- LBL instr=9'b101_110_000 (index 6) → illegal_op pulse; label_write never asserts.
- instr=9'h1FF → halted=1 and instr_ready=0 held for 20 cycles; reset clears both.
- Reset asserted during EXEC while alu_done is pending → reg_write is never asserted; FSM returns to IDLE.
